// File: rtl/alu_pkg.sv
// Shared types for the ALU issue queue: opcode encoding and command layout.
// Opcode values are the MUX8 input indices of the function units.
package alu_pkg;

  typedef logic [2:0] alu_op_t;

  typedef struct packed {
    alu_op_t    op;
    logic [7:0] a;
    logic [7:0] b;
  } alu_cmd_t;

  localparam alu_op_t OP_ADD  = 3'd0;
  localparam alu_op_t OP_SUB  = 3'd1;
  localparam alu_op_t OP_OR   = 3'd2;
  localparam alu_op_t OP_AND  = 3'd3;
  localparam alu_op_t OP_XOR  = 3'd4;
  localparam alu_op_t OP_SHL  = 3'd5;
  localparam alu_op_t OP_SHR  = 3'd6;
  localparam alu_op_t OP_PASS = 3'd7;

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: DEPTH entries of alu_cmd_t, combinational head read.
// Occupancy is tracked in count; the pointers wrap freely and are never
// compared against each other. The caller guarantees no push when full and
// no pop when empty.
module cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  alu_cmd_t         wdata,
  output alu_cmd_t         head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  alu_cmd_t         mem_q [DEPTH];
  alu_cmd_t         mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wdata;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy state; reset discards everything queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Empty queue presents an all-zero head so the mux sees a quiet select.
  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/alu_issue_queue.sv
// ALU issue queue: buffers commands, drives the head entry onto the function
// unit operand buses and the MUX8 select, and captures the selected result
// into a valid/ready output register toward write-back.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int SEL_W = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [SEL_W-1:0]             cmd_op,
  input  logic [W-1:0]                 cmd_a,
  input  logic [W-1:0]                 cmd_b,
  output logic [W-1:0]                 op_a,
  output logic [W-1:0]                 op_b,
  output logic [SEL_W-1:0]             select,
  input  logic [W-1:0]                 mux_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [W-1:0]                 res_data,
  output logic [SEL_W-1:0]             res_op,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  alu_cmd_t   wdata;
  alu_cmd_t   head;
  logic       push;
  logic       fire;

  logic             res_valid_q, res_valid_d;
  logic [W-1:0]     res_data_q,  res_data_d;
  logic [SEL_W-1:0] res_op_q,    res_op_d;

  assign wdata = {cmd_op, cmd_a, cmd_b};

  cmd_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (fire),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

  // Ready depends only on registered occupancy, never on this cycle's pop.
  assign cmd_ready = !rst && (count < DEPTH_C);
  assign push      = cmd_valid && cmd_ready;

  // Head issues when the output register is free or being drained now.
  assign fire = (count != '0) && (!res_valid_q || res_ready);

  assign select = head.op;
  assign op_a   = head.a;
  assign op_b   = head.b;

  // Result register: capture on fire, clear valid once drained with nothing queued.
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    if (fire) begin
      res_valid_d = 1'b1;
      res_data_d  = mux_out;
      res_op_d    = head.op;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural MUX8 + function units.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_issue_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic [7:0] op_a, op_b;
  logic [2:0] select;
  logic [7:0] mux_out;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic [2:0] res_op;
  logic [2:0] count;

  int vectors = 0;
  int miscompares = 0;

  // Hand-computed results of every opcode for a=0x35, b=0x0C.
  logic [7:0] exp_tab [8] = '{8'h41, 8'h29, 8'h3D, 8'h04, 8'h39, 8'h50, 8'h03, 8'h35};

  always #5 clk = ~clk;

  // Environment model: function units feeding the 8-input mux.
  always_comb begin
    case (select)
      3'd0: mux_out = op_a + op_b;
      3'd1: mux_out = op_a - op_b;
      3'd2: mux_out = op_a | op_b;
      3'd3: mux_out = op_a & op_b;
      3'd4: mux_out = op_a ^ op_b;
      3'd5: mux_out = op_a << op_b[2:0];
      3'd6: mux_out = op_a >> op_b[2:0];
      default: mux_out = op_a;
    endcase
  end

  alu_issue_queue dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .op_a(op_a), .op_b(op_b), .select(select), .mux_out(mux_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_op(res_op), .count(count)
  );

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
    vectors++; if ({select, op_a, op_b} !== 19'd0) begin miscompares++; $display("FAIL reset_head got %h exp 0", {select, op_a, op_b}); end
    vectors++; if ({res_data, res_op} !== 11'd0) begin miscompares++; $display("FAIL reset_res got %h exp 0", {res_data, res_op}); end
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 8'h11; cmd_b = 8'h22;
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++; if (select !== 3'd2) begin miscompares++; $display("FAIL single_select got %0d exp 2", select); end
    vectors++; if ({op_a, op_b} !== 16'h1122) begin miscompares++; $display("FAIL single_ops got %h exp 1122", {op_a, op_b}); end
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL single_count got %0d exp 1", count); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL single_nobypass got %b exp 0", res_valid); end
    @(negedge clk);
    vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL single_res_valid got %b exp 1", res_valid); end
    vectors++; if (res_data !== 8'h33) begin miscompares++; $display("FAIL single_res_data got %h exp 33", res_data); end
    vectors++; if (res_op !== 3'd2) begin miscompares++; $display("FAIL single_res_op got %0d exp 2", res_op); end
    vectors++; if ({count, select} !== 6'd0) begin miscompares++; $display("FAIL single_empty got %h exp 0", {count, select}); end
    @(negedge clk);
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain got %b exp 0", res_valid); end
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b1; cmd_a = 8'h35; cmd_b = 8'h0C;
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) begin
        vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid[%0d] got %b exp 1", i - 2, res_valid); end
        vectors++; if (res_op !== 3'(i - 2)) begin miscompares++; $display("FAIL b2b_op[%0d] got %0d exp %0d", i - 2, res_op, i - 2); end
        vectors++; if (res_data !== exp_tab[i - 2]) begin miscompares++; $display("FAIL b2b_data[%0d] got %h exp %h", i - 2, res_data, exp_tab[i - 2]); end
      end
      if (i >= 1) begin
        vectors++; if (count > 3'd1) begin miscompares++; $display("FAIL b2b_count[%0d] got %0d exp <=1", i, count); end
      end
      if (i < 8) begin cmd_valid = 1'b1; cmd_op = 3'(i); end
      else cmd_valid = 1'b0;
      @(negedge clk);
    end
    vectors++; if ({res_valid, count} !== 4'd0) begin miscompares++; $display("FAIL b2b_idle got %h exp 0", {res_valid, count}); end
  endtask

  task automatic test_backpressure();
    logic [2:0] ops [6] = '{3'd3, 3'd5, 3'd6, 3'd1, 3'd7, 3'd4};
    res_ready = 1'b0; cmd_a = 8'h35; cmd_b = 8'h0C;
    // five pushes: first lands in the result register, four fill the FIFO
    for (int k = 0; k < 5; k++) begin
      cmd_valid = 1'b1; cmd_op = ops[k];
      @(negedge clk);
    end
    // offer a sixth that must stall
    cmd_op = ops[5];
    for (int k = 0; k < 3; k++) begin
      vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL bp_count[%0d] got %0d exp 4", k, count); end
      vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready[%0d] got %b exp 0", k, cmd_ready); end
      vectors++; if ({res_valid, res_op, res_data} !== {1'b1, ops[0], exp_tab[ops[0]]}) begin
        miscompares++; $display("FAIL bp_hold[%0d] got %h exp %h", k, {res_valid, res_op, res_data}, {1'b1, ops[0], exp_tab[ops[0]]}); end
      vectors++; if (select !== ops[1]) begin miscompares++; $display("FAIL bp_head[%0d] got %0d exp %0d", k, select, ops[1]); end
      @(negedge clk);
    end
    // full plus a single-cycle pop
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL fullpop_count got %0d exp 3", count); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL fullpop_ready got %b exp 1", cmd_ready); end
    vectors++; if (res_op !== ops[1]) begin miscompares++; $display("FAIL fullpop_op got %0d exp %0d", res_op, ops[1]); end
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL refill_count got %0d exp 4", count); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL refill_ready got %b exp 0", cmd_ready); end
    // drain the rest in order
    res_ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      vectors++; if ({res_valid, res_op, res_data} !== {1'b1, ops[k], exp_tab[ops[k]]}) begin
        miscompares++; $display("FAIL drain[%0d] got %h exp %h", k, {res_valid, res_op, res_data}, {1'b1, ops[k], exp_tab[ops[k]]}); end
      @(negedge clk);
    end
    vectors++; if ({res_valid, count} !== 4'd0) begin miscompares++; $display("FAIL drain_idle got %h exp 0", {res_valid, count}); end
  endtask

  task automatic test_async_reset();
    res_ready = 1'b0; cmd_valid = 1'b1; cmd_a = 8'h35; cmd_b = 8'h0C;
    for (int k = 0; k < 4; k++) begin
      cmd_op = 3'(k + 1);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    vectors++; if ({res_valid, count} !== {1'b1, 3'd3}) begin miscompares++; $display("FAIL pre_rst got %h exp b", {res_valid, count}); end
    #2 rst = 1'b1;
    #1;
    vectors++; if ({count, cmd_ready, res_valid} !== 5'd0) begin miscompares++; $display("FAIL rst_ctrl got %h exp 0", {count, cmd_ready, res_valid}); end
    vectors++; if ({res_data, res_op, select, op_a, op_b} !== 30'd0) begin
      miscompares++; $display("FAIL rst_data got %h exp 0", {res_data, res_op, select, op_a, op_b}); end
    @(negedge clk);
    rst = 1'b0; res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++; if ({res_valid, count, select} !== 7'd0) begin miscompares++; $display("FAIL post_rst[%0d] got %h exp 0", k, {res_valid, count, select}); end
      vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready[%0d] got %b exp 1", k, cmd_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
